// File: rtl/track_volume_ctrl_pkg.sv
// Shared definitions for the track/volume controller: widths, command bit
// layout and the track-switch handshake states.
package track_volume_ctrl_pkg;

  localparam int TRACK_W  = 3;
  localparam int VOLUME_W = 4;
  localparam int STEP_W   = 3;
  localparam int CMD_W    = 8;

  // cmd = {PREV, NEXT, UP, DOWN}
  localparam int CMD_DOWN_BIT = 0;
  localparam int CMD_UP_BIT   = 1;
  localparam int CMD_NEXT_LSB = 2;
  localparam int CMD_PREV_LSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/track_volume_ctrl_cmd_edge_detect.sv
// Flags a new remote command: the vector differs from last cycle's and is
// not all-zero, so a held command fires once and repeats need a zero gap.
module track_volume_ctrl_cmd_edge_detect
  import track_volume_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [CMD_W-1:0] cmd,
  output logic             evt,
  output logic [CMD_W-1:0] evt_cmd
);

  logic [CMD_W-1:0] cmd_prev_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_prev_reg <= '0;
    end else begin
      cmd_prev_reg <= cmd;
    end
  end

  assign evt     = (cmd != cmd_prev_reg) && (cmd != '0);
  assign evt_cmd = cmd;

endmodule

// File: rtl/track_volume_ctrl.sv
// Turns decoded remote commands into saturating volume steps or wrapped
// track moves, stopping the player via a request/ack handshake first.
module track_volume_ctrl
  import track_volume_ctrl_pkg::*;
#(
  parameter int NUM_TRACKS  = 8,
  parameter int VOL_MAX     = 15,
  parameter int VOL_INIT    = 8,
  parameter int ACK_TIMEOUT = 50000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [STEP_W-1:0]   PREV,
  input  logic [STEP_W-1:0]   NEXT,
  input  logic                UP,
  input  logic                DOWN,
  input  logic                SWITCH_ACK,
  output logic [TRACK_W-1:0]  TRACK,
  output logic [VOLUME_W-1:0] VOLUME,
  output logic                SWITCH_REQ,
  output logic                TRACK_CHANGED,
  output logic                BUSY
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [TRACK_W-1:0]  TRACK_MASK = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [VOLUME_W-1:0] VOL_TOP    = VOLUME_W'(VOL_MAX);

  // One extra bit keeps the borrow of a backward step from leaking into the mask.
  function automatic logic [TRACK_W-1:0] step_track(input logic [TRACK_W-1:0] cur,
                                                     input logic [STEP_W-1:0]  step,
                                                     input logic               fwd);
    logic [TRACK_W:0] sum;
    sum = fwd ? ({1'b0, cur} + {1'b0, step}) : ({1'b0, cur} - {1'b0, step});
    return TRACK_W'(sum & {1'b0, TRACK_MASK});
  endfunction

  logic               evt;
  logic [CMD_W-1:0]   evt_cmd;
  logic [STEP_W-1:0]  evt_next_step, evt_prev_step, evt_step;
  logic               evt_fwd, track_evt, vol_evt;

  state_t               state_reg, state_next;
  logic [TRACK_W-1:0]   track_reg, track_next, target_reg, target_next, cand;
  logic [VOLUME_W-1:0]  volume_reg, volume_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 pend_valid_reg, pend_valid_next, pend_fwd_reg, pend_fwd_next;
  logic [STEP_W-1:0]    pend_step_reg, pend_step_next, sel_step;
  logic                 sel_valid, sel_fwd;

  track_volume_ctrl_cmd_edge_detect u_edge (
    .CLK     (CLK),
    .RST     (RST),
    .cmd     ({PREV, NEXT, UP, DOWN}),
    .evt     (evt),
    .evt_cmd (evt_cmd)
  );

  assign evt_next_step = evt_cmd[CMD_NEXT_LSB +: STEP_W];
  assign evt_prev_step = evt_cmd[CMD_PREV_LSB +: STEP_W];
  assign evt_fwd       = (evt_next_step != '0);
  assign evt_step      = evt_fwd ? evt_next_step : evt_prev_step;
  assign track_evt     = evt && ((evt_next_step != '0) || (evt_prev_step != '0));
  assign vol_evt       = evt && !track_evt;

  always_comb begin
    volume_next = volume_reg;
    if (vol_evt) begin
      if (evt_cmd[CMD_UP_BIT] && !evt_cmd[CMD_DOWN_BIT] && (volume_reg < VOL_TOP)) begin
        volume_next = volume_reg + VOLUME_W'(1);
      end else if (evt_cmd[CMD_DOWN_BIT] && !evt_cmd[CMD_UP_BIT] && (volume_reg != '0)) begin
        volume_next = volume_reg - VOLUME_W'(1);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    track_next      = track_reg;
    target_next     = target_reg;
    cnt_next        = cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_step_next  = pend_step_reg;
    pend_fwd_next   = pend_fwd_reg;
    sel_valid       = 1'b0;
    sel_step        = evt_step;
    sel_fwd         = evt_fwd;
    case (state_reg)
      ST_IDLE: begin
        sel_valid = track_evt;
      end
      ST_REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (track_evt) begin
          pend_valid_next = 1'b1;
          pend_step_next  = evt_step;
          pend_fwd_next   = evt_fwd;
        end
        if (SWITCH_ACK || (cnt_reg == CNT_LAST)) begin
          state_next = ST_COMMIT;
          track_next = target_reg;
        end
      end
      ST_COMMIT: begin
        // TRACK already holds the new index here, so pending steps apply to it.
        cnt_next        = '0;
        state_next      = ST_IDLE;
        pend_valid_next = 1'b0;
        if (track_evt) begin
          sel_valid = 1'b1;
        end else if (pend_valid_reg) begin
          sel_valid = 1'b1;
          sel_step  = pend_step_reg;
          sel_fwd   = pend_fwd_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    cand = step_track(track_reg, sel_step, sel_fwd);
    if (sel_valid && (cand != track_reg)) begin
      target_next = cand;
      state_next  = ST_REQ;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      track_reg      <= '0;
      target_reg     <= '0;
      volume_reg     <= VOLUME_W'(VOL_INIT);
      cnt_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_step_reg  <= '0;
      pend_fwd_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      track_reg      <= track_next;
      target_reg     <= target_next;
      volume_reg     <= volume_next;
      cnt_reg        <= cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_step_reg  <= pend_step_next;
      pend_fwd_reg   <= pend_fwd_next;
    end
  end

  assign TRACK         = track_reg;
  assign VOLUME        = volume_reg;
  assign SWITCH_REQ    = (state_reg == ST_REQ);
  assign TRACK_CHANGED = (state_reg == ST_COMMIT);
  assign BUSY          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_track_volume_ctrl.sv
// Self-checking bench for track_volume_ctrl: directed vector table, hand
// sequences for handshake corners, then random commands against a model.
module tb_track_volume_ctrl;

  localparam int NT    = 8;
  localparam int VMAX  = 15;
  localparam int VINIT = 8;
  localparam int TO    = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] prev_d = '0, next_d = '0;
  logic       up_d = 1'b0, down_d = 1'b0, ack_d = 1'b0;
  logic [2:0] TRACK;
  logic [3:0] VOLUME;
  logic       SWITCH_REQ, TRACK_CHANGED, BUSY;

  int checks = 0;
  int failures = 0;
  int req_seen = 0;
  int pulse_seen = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 committing.
  int m_track, m_vol, m_phase, m_wait, m_target;
  int m_pend[$];
  logic [7:0] m_last;

  typedef struct {
    logic [2:0] prev;
    logic [2:0] next;
    logic       up;
    logic       down;
    logic       ack;
    int         ncyc;
    int         exp_track;
    int         exp_vol;
    int         exp_busy;
  } vec_t;
  vec_t vecs[$];

  track_volume_ctrl #(
    .NUM_TRACKS (NT),
    .VOL_MAX    (VMAX),
    .VOL_INIT   (VINIT),
    .ACK_TIMEOUT(TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PREV         (prev_d),
    .NEXT         (next_d),
    .UP           (up_d),
    .DOWN         (down_d),
    .SWITCH_ACK   (ack_d),
    .TRACK        (TRACK),
    .VOLUME       (VOLUME),
    .SWITCH_REQ   (SWITCH_REQ),
    .TRACK_CHANGED(TRACK_CHANGED),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int wrap(int v);
    return ((v % NT) + NT) % NT;
  endfunction

  function automatic void model_reset();
    m_track  = 0;
    m_vol    = VINIT;
    m_phase  = 0;
    m_wait   = 0;
    m_target = 0;
    m_last   = '0;
    m_pend.delete();
  endfunction

  function automatic void add_vec(int p, int n, int u, int d, int a, int c, int t, int v, int b);
    vec_t e;
    e.prev = 3'(p); e.next = 3'(n); e.up = 1'(u); e.down = 1'(d); e.ack = 1'(a);
    e.ncyc = c; e.exp_track = t; e.exp_vol = v; e.exp_busy = b;
    vecs.push_back(e);
  endfunction

  // Advance the model across one rising edge using the inputs the DUT sees.
  task automatic model_edge();
    logic [7:0] c;
    bit ev, tev, have;
    int delta, d;
    if (RST) begin
      model_reset();
      return;
    end
    c      = {prev_d, next_d, up_d, down_d};
    ev     = (c != m_last) && (c != 8'd0);
    m_last = c;
    tev    = ev && ((next_d != 0) || (prev_d != 0));
    delta  = (next_d != 0) ? int'(next_d) : -int'(prev_d);
    if (ev && !tev) begin
      if (up_d && !down_d && m_vol < VMAX) m_vol++;
      else if (down_d && !up_d && m_vol > 0) m_vol--;
    end
    case (m_phase)
      0: if (tev && wrap(m_track + delta) != m_track) begin
           m_target = wrap(m_track + delta);
           m_phase  = 1;
           m_wait   = 0;
         end
      1: begin
           if (tev) begin
             m_pend.delete();
             m_pend.push_back(delta);
           end
           if (ack_d || m_wait == TO - 1) begin
             m_track = m_target;
             m_phase = 2;
           end else begin
             m_wait++;
           end
         end
      default: begin
           have = 1'b0;
           d = 0;
           if (tev) begin
             d = delta; have = 1'b1;
           end else if (m_pend.size() > 0) begin
             d = m_pend[0]; have = 1'b1;
           end
           m_pend.delete();
           m_phase = 0;
           if (have && wrap(m_track + d) != m_track) begin
             m_target = wrap(m_track + d);
             m_phase  = 1;
             m_wait   = 0;
           end
         end
    endcase
  endtask

  task automatic compare_all();
    chk("track", TRACK, m_track);
    chk("volume", VOLUME, m_vol);
    chk("switch_req", SWITCH_REQ, m_phase == 1);
    chk("track_changed", TRACK_CHANGED, m_phase == 2);
    chk("busy", BUSY, m_phase != 0);
    if (SWITCH_REQ) req_seen++;
    if (TRACK_CHANGED) pulse_seen++;
  endtask

  task automatic step_cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic set_cmd(int p, int n, int u, int d, int a);
    prev_d = 3'(p); next_d = 3'(n); up_d = 1'(u); down_d = 1'(d); ack_d = 1'(a);
  endtask

  initial begin
    // prev, next, up, down, ack, cycles, exp track, exp volume, exp busy
    add_vec(0, 3, 0, 0, 0, 1, 0, 8, 1);
    add_vec(0, 3, 0, 0, 0, 1, 0, 8, 1);
    add_vec(0, 3, 0, 0, 1, 1, 3, 8, 1);
    add_vec(0, 3, 0, 0, 0, 7, 3, 8, 0);
    add_vec(0, 0, 0, 0, 0, 1, 3, 8, 0);
    add_vec(2, 0, 0, 0, 0, 1, 3, 8, 1);
    add_vec(2, 0, 0, 0, 1, 1, 1, 8, 1);
    add_vec(0, 0, 0, 0, 0, 2, 1, 8, 0);
    add_vec(3, 0, 0, 0, 0, 5, 1, 8, 1);
    add_vec(3, 0, 0, 0, 1, 1, 6, 8, 1);
    add_vec(3, 0, 0, 0, 0, 6, 6, 8, 0);
    add_vec(0, 0, 0, 0, 0, 1, 6, 8, 0);
    add_vec(0, 0, 1, 0, 0, 1, 6, 9, 0);
    add_vec(0, 0, 0, 0, 0, 1, 6, 9, 0);
    add_vec(0, 0, 1, 1, 0, 1, 6, 9, 0);
    add_vec(0, 0, 0, 0, 0, 1, 6, 9, 0);
    add_vec(2, 1, 0, 0, 0, 1, 6, 9, 1);
    add_vec(2, 1, 0, 0, 1, 1, 7, 9, 1);
    add_vec(0, 0, 0, 0, 0, 1, 7, 9, 0);

    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_track", TRACK, 0);
    chk("reset_volume", VOLUME, VINIT);
    chk("reset_req", SWITCH_REQ, 0);
    chk("reset_pulse", TRACK_CHANGED, 0);
    chk("reset_busy", BUSY, 0);
    @(negedge CLK);

    req_seen = 0;
    pulse_seen = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      set_cmd(vecs[i].prev, vecs[i].next, vecs[i].up, vecs[i].down, vecs[i].ack);
      repeat (vecs[i].ncyc) step_cycle();
      chk("vec_track", TRACK, vecs[i].exp_track);
      chk("vec_volume", VOLUME, vecs[i].exp_vol);
      chk("vec_busy", BUSY, vecs[i].exp_busy);
      $display("vec %0d: prev=%0d next=%0d up=%0b down=%0b ack=%0b -> track=%0d volume=%0d busy=%0b",
               i, vecs[i].prev, vecs[i].next, vecs[i].up, vecs[i].down, vecs[i].ack,
               TRACK, VOLUME, BUSY);
      if (i == 3) begin
        chk("held_next_req_cycles", req_seen, 2);
        chk("held_next_pulses", pulse_seen, 1);
      end
    end

    // Volume saturation at both ends.
    for (int i = 0; i < 8; i++) begin
      set_cmd(0, 0, 1, 0, 0); step_cycle();
      set_cmd(0, 0, 0, 0, 0); step_cycle();
    end
    chk("vol_reach_max", VOLUME, 15);
    for (int i = 0; i < 3; i++) begin
      set_cmd(0, 0, 1, 0, 0); step_cycle();
      chk("vol_hold_max", VOLUME, 15);
      set_cmd(0, 0, 0, 0, 0); step_cycle();
    end
    for (int i = 0; i < 16; i++) begin
      set_cmd(0, 0, 0, 1, 0); step_cycle();
      set_cmd(0, 0, 0, 0, 0); step_cycle();
    end
    chk("vol_reach_zero", VOLUME, 0);
    set_cmd(0, 0, 0, 1, 0); step_cycle();
    chk("vol_hold_zero", VOLUME, 0);
    set_cmd(0, 0, 0, 0, 0); step_cycle();
    $display("volume saturation: volume=%0d", VOLUME);

    // ACK never arrives: request must time out after TO cycles.
    begin
      int reqc;
      bit got;
      reqc = 0;
      got = 1'b0;
      set_cmd(0, 2, 0, 0, 0);
      for (int k = 0; k < 40 && !got; k++) begin
        step_cycle();
        if (SWITCH_REQ) reqc++;
        if (TRACK_CHANGED) begin
          got = 1'b1;
          chk("timeout_track", TRACK, 1);
        end
      end
      chk("timeout_req_cycles", reqc, TO);
      chk("timeout_pulse_seen", got, 1);
      $display("timeout: req_cycles=%0d track=%0d", reqc, TRACK);
      set_cmd(0, 0, 0, 0, 0);
      repeat (2) step_cycle();
    end

    // Asynchronous reset in the middle of a request.
    set_cmd(0, 3, 0, 0, 0);
    repeat (3) step_cycle();
    chk("pre_reset_req", SWITCH_REQ, 1);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("async_rst_req", SWITCH_REQ, 0);
    chk("async_rst_track", TRACK, 0);
    chk("async_rst_volume", VOLUME, VINIT);
    chk("async_rst_busy", BUSY, 0);
    set_cmd(0, 0, 0, 0, 0);
    @(negedge CLK);
    step_cycle();
    RST = 1'b0;
    repeat (2) step_cycle();
    $display("async reset: track=%0d volume=%0d busy=%0b", TRACK, VOLUME, BUSY);

    // Event during REQ is held pending and replayed from the committed track.
    set_cmd(0, 1, 0, 0, 0); step_cycle();
    set_cmd(0, 0, 0, 0, 0); step_cycle();
    set_cmd(2, 0, 0, 0, 0); step_cycle();
    ack_d = 1'b1; step_cycle();
    chk("pend_commit1_track", TRACK, 1);
    chk("pend_commit1_pulse", TRACK_CHANGED, 1);
    ack_d = 1'b0; step_cycle();
    chk("pend_rereq", SWITCH_REQ, 1);
    ack_d = 1'b1; step_cycle();
    chk("pend_commit2_track", TRACK, 7);
    chk("pend_commit2_pulse", TRACK_CHANGED, 1);
    set_cmd(0, 0, 0, 0, 0);
    repeat (2) step_cycle();
    chk("pend_idle", BUSY, 0);
    $display("pending: track=%0d", TRACK);

    // Random commands against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 9))
          4: set_cmd(0, $urandom_range(1, 7), 0, 0, 0);
          5: set_cmd($urandom_range(1, 7), 0, 0, 0, 0);
          6: set_cmd(0, 0, 1, 0, 0);
          7: set_cmd(0, 0, 0, 1, 0);
          8: set_cmd(0, 0, 1, 1, 0);
          9: set_cmd($urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 1), 0);
          default: set_cmd(0, 0, 0, 0, 0);
        endcase
      end
      ack_d = ($urandom_range(0, 3) == 0);
      step_cycle();
    end
    $display("random: track=%0d volume=%0d req_cycles=%0d pulses=%0d",
             TRACK, VOLUME, req_seen, pulse_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
